mvm_uart_host: RTL and testbench

Host-side UART endpoint for the matrix-vector multiplier link, and the mirror image of the accelerator's UART system. It accepts one packed K/X operand word on an AXI-Stream slave port and serializes it byte-by-byte onto `tx`. Independently, it deserializes the R×32-bit result stream arriving on `rx` into one wide word presented on an AXI-Stream master port. It serves as an on-chip/bench stand-in for the PC, and as a loopback partner for system-level tests.

---
 rtl/mvm_uart_host.sv | 243 ++++++++++++++++++++++++
 tb/tb_mvm_uart_host.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_uart_host.sv
// Host-side UART endpoint: serializes one wide operand word onto tx and
// reassembles the incoming byte stream on rx into one wide result word.
module mvm_uart_host #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8,
    parameter int STOP_BITS_TX     = 4,
    parameter int W_TX             = 224,
    parameter int W_RX             = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [W_TX-1:0]   s_axis_tdata,
    output logic              tx,
    input  logic              rx,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [W_RX-1:0]   m_axis_tdata,
    output logic              frame_err,
    output logic              overrun
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both 1; valid/data never change while valid waits for ready.

    localparam int N_TX   = W_TX / BITS_PER_WORD;
    localparam int N_RX   = W_RX / BITS_PER_WORD;
    localparam int F_TX   = 1 + BITS_PER_WORD + STOP_BITS_TX;
    localparam int CW     = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int BIT_W  = $clog2(F_TX + 1);
    localparam int TXB_W  = $clog2(N_TX + 1);
    localparam int DB_W   = $clog2(BITS_PER_WORD + 1);
    localparam int RXB_W  = $clog2(N_RX + 1);

    localparam logic [CW-1:0]    CYC_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0]    CYC_HALF  = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(F_TX - 1);
    localparam logic [TXB_W-1:0] TXB_LAST  = TXB_W'(N_TX - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(BITS_PER_WORD - 1);
    localparam logic [RXB_W-1:0] RXB_LAST  = RXB_W'(N_RX - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    function automatic logic [F_TX-1:0] make_frame(input logic [BITS_PER_WORD-1:0] b);
        return {{STOP_BITS_TX{1'b1}}, b, 1'b0};
    endfunction

    // ---------------- TX path ----------------
    tx_state_e          tx_state_q, tx_state_d;
    logic [W_TX-1:0]    tx_word_q,  tx_word_d;
    logic [F_TX-1:0]    tx_frame_q, tx_frame_d;
    logic [CW-1:0]      tx_cyc_q,   tx_cyc_d;
    logic [BIT_W-1:0]   tx_bit_q,   tx_bit_d;
    logic [TXB_W-1:0]   tx_byte_q,  tx_byte_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_q <= TX_IDLE;
            tx_word_q  <= '0;
            tx_frame_q <= '1;
            tx_cyc_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_word_q  <= tx_word_d;
            tx_frame_q <= tx_frame_d;
            tx_cyc_q   <= tx_cyc_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // tx_word_q holds the bytes not yet framed, next byte in the low bits.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_word_d  = tx_word_q;
        tx_frame_d = tx_frame_q;
        tx_cyc_d   = tx_cyc_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (s_axis_tvalid) begin
                    tx_state_d = TX_SEND;
                    tx_frame_d = make_frame(s_axis_tdata[BITS_PER_WORD-1:0]);
                    tx_word_d  = s_axis_tdata >> BITS_PER_WORD;
                    tx_cyc_d   = '0;
                    tx_bit_d   = '0;
                    tx_byte_d  = '0;
                end
            end
            TX_SEND: begin
                if (tx_cyc_q == CYC_LAST) begin
                    tx_cyc_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_bit_d = '0;
                        if (tx_byte_q == TXB_LAST) begin
                            tx_state_d = TX_IDLE;
                        end else begin
                            tx_byte_d  = tx_byte_q + TXB_W'(1);
                            tx_frame_d = make_frame(tx_word_q[BITS_PER_WORD-1:0]);
                            tx_word_d  = tx_word_q >> BITS_PER_WORD;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        tx_frame_d = {1'b1, tx_frame_q[F_TX-1:1]};
                    end
                end else begin
                    tx_cyc_d = tx_cyc_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign s_axis_tready = (tx_state_q == TX_IDLE);
    assign tx            = (tx_state_q == TX_SEND) ? tx_frame_q[0] : 1'b1;

    // ---------------- RX path ----------------
    logic                     rx_meta_q, rx_sync_q;
    rx_state_e                rx_state_q, rx_state_d;
    logic [CW-1:0]            rx_cyc_q,   rx_cyc_d;
    logic [DB_W-1:0]          rx_bit_q,   rx_bit_d;
    logic [BITS_PER_WORD-1:0] rx_shift_q, rx_shift_d;
    logic [RXB_W-1:0]         rx_cnt_q,   rx_cnt_d;
    logic [W_RX-1:0]          asm_q,      asm_d;
    logic [W_RX-1:0]          m_data_q,   m_data_d;
    logic                     m_valid_q,  m_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     overrun_q,   overrun_d;

    logic [BITS_PER_WORD:0]            shift_cat;
    logic [W_RX+BITS_PER_WORD-1:0]     asm_cat;

    // New bytes enter at the top, so after N_RX bytes byte k sits at [8k+7:8k].
    assign shift_cat = {rx_sync_q, rx_shift_q};
    assign asm_cat   = {rx_shift_q, asm_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cyc_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_cnt_q    <= '0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cyc_q    <= rx_cyc_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            asm_q       <= asm_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cyc_d    = rx_cyc_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        asm_d       = asm_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q & ~m_axis_tready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cyc_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cyc_q == CYC_HALF) begin
                    rx_cyc_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cyc_d = rx_cyc_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cyc_q == CYC_LAST) begin
                    rx_cyc_d   = '0;
                    rx_shift_d = shift_cat[BITS_PER_WORD:1];
                    rx_bit_d   = rx_bit_q + DB_W'(1);
                    if (rx_bit_q == DB_LAST) rx_state_d = RX_STOP;
                end else begin
                    rx_cyc_d = rx_cyc_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cyc_q == CYC_LAST) begin
                    rx_cyc_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        asm_d = asm_cat[W_RX+BITS_PER_WORD-1:BITS_PER_WORD];
                        if (rx_cnt_q == RXB_LAST) begin
                            rx_cnt_d = '0;
                            // A word still waiting downstream wins; the new one is dropped.
                            if (m_valid_d) begin
                                overrun_d = 1'b1;
                            end else begin
                                m_data_d  = asm_d;
                                m_valid_d = 1'b1;
                            end
                        end else begin
                            rx_cnt_d = rx_cnt_q + RXB_W'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cyc_d = rx_cyc_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_mvm_uart_host.sv
// Self-checking bench for mvm_uart_host: tx bit timing, loopback, glitch,
// framing error, overrun and mid-frame reset, with a result-word scoreboard.
`timescale 1ns/1ps
module tb_mvm_uart_host;

  localparam int CPP = 4;
  localparam int W   = 16;

  logic          clk;
  logic          rstn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata;
  logic          tx;
  logic          rx_line;
  logic          rx_drv;
  logic          loop_en;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          frame_err;
  logic          overrun;

  int tests_run = 0;
  int tests_failed = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;

  assign rx_line = loop_en ? tx : rx_drv;

  mvm_uart_host #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(8),
    .STOP_BITS_TX(4),
    .W_TX(W),
    .W_RX(W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .tx(tx),
    .rx(rx_line),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop one expected word per output handshake
  always @(negedge clk) begin
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("rx_unexpected_word", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_word = exp_q.pop_front();
        check("rx_word", 32'(m_axis_tdata), 32'(exp_word));
      end
    end
    if (rstn && frame_err) fe_cnt++;
    if (rstn && overrun) ov_cnt++;
  end

  // driver tasks
  task automatic send_word(input logic [W-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!s_axis_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) check("tx_accept_timeout", 32'(s_axis_tready), 32'd1);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic uart_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPP) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (CPP) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPP) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!m_axis_tvalid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!m_axis_tvalid) check("rx_valid_timeout", 32'(m_axis_tvalid), 32'd1);
  endtask

  task automatic wait_rx_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("rx_drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_tx_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!s_axis_tready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) check("tx_idle_timeout", 32'(s_axis_tready), 32'd1);
  endtask

  // Sends d and checks every cycle of the 2 x 13-bit frame sequence on tx.
  task automatic tx_word_check(input logic [W-1:0] d);
    logic [25:0] bits;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 13; j++) begin
        if (j == 0)      bits[k*13+j] = 1'b0;
        else if (j <= 8) bits[k*13+j] = d[k*8+j-1];
        else             bits[k*13+j] = 1'b1;
      end
    end
    send_word(d);
    for (int c = 1; c <= 26 * CPP; c++) begin
      @(negedge clk);
      check("tx_bit", 32'(tx), 32'(bits[(c-1)/CPP]));
      if (c == 1 || c == 26 * CPP) check("tx_busy_ready", 32'(s_axis_tready), 32'd0);
    end
    @(negedge clk);
    check("tx_ready_return", 32'(s_axis_tready), 32'd1);
    check("tx_idle_line", 32'(tx), 32'd1);
  endtask

  initial begin
    int fe_base;
    int ov_base;
    logic [W-1:0] w;

    rstn          = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    rx_drv        = 1'b1;
    loop_en       = 1'b0;
    m_axis_tready = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tready", 32'(s_axis_tready), 32'd1);
    check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_mdata", 32'(m_axis_tdata), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // TX serialization of 0xA55A
    tx_word_check(16'hA55A);

    // Loopback 0x1234, result held until tready
    loop_en = 1'b1;
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    wait_valid(600);
    check("loop_data", 32'(m_axis_tdata), 32'h1234);
    repeat (5) @(negedge clk);
    check("loop_hold_valid", 32'(m_axis_tvalid), 32'd1);
    check("loop_hold_data", 32'(m_axis_tdata), 32'h1234);
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    @(posedge clk);
    #1 check("loop_valid_clear", 32'(m_axis_tvalid), 32'd0);
    wait_rx_drain(50);
    wait_tx_idle(600);
    loop_en = 1'b0;
    repeat (4) @(negedge clk);

    // Glitch then valid 0x00FF
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_no_word", 32'(m_axis_tvalid), 32'd0);
    exp_q.push_back(16'h00FF);
    uart_byte(8'hFF, 1'b1);
    uart_byte(8'h00, 1'b1);
    wait_rx_drain(200);

    // Framing error
    fe_base = fe_cnt;
    uart_byte(8'h34, 1'b0);
    check("frame_err_pulses", 32'(fe_cnt - fe_base), 32'd1);
    check("frame_err_no_word", 32'(m_axis_tvalid), 32'd0);
    exp_q.push_back(16'h1234);
    uart_byte(8'h34, 1'b1);
    uart_byte(8'h12, 1'b1);
    wait_rx_drain(200);
    check("frame_err_extra", 32'(fe_cnt - fe_base), 32'd1);

    // Overrun
    m_axis_tready = 1'b0;
    ov_base = ov_cnt;
    exp_q.push_back(16'hBEEF);
    uart_byte(8'hEF, 1'b1);
    uart_byte(8'hBE, 1'b1);
    wait_valid(200);
    check("ovr_first_data", 32'(m_axis_tdata), 32'hBEEF);
    uart_byte(8'h11, 1'b1);
    uart_byte(8'h11, 1'b1);
    check("ovr_pulses", 32'(ov_cnt - ov_base), 32'd1);
    check("ovr_held_data", 32'(m_axis_tdata), 32'hBEEF);
    check("ovr_held_valid", 32'(m_axis_tvalid), 32'd1);

    // Asynchronous reset mid-transmission
    send_word(16'h0000);
    repeat (6) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx), 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_tready", 32'(s_axis_tready), 32'd1);
    check("arst_mvalid", 32'(m_axis_tvalid), 32'd0);
    check("arst_mdata", 32'(m_axis_tdata), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    tx_word_check(16'hA55A);

    // Random loopback words
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = W'($urandom_range(0, 16'hFFFF));
      exp_q.push_back(w);
      send_word(w);
      wait_rx_drain(600);
    end
    wait_tx_idle(600);
    loop_en = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
